// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch stage in front of decode. It reads a byte-wide, big-endian
//   instruction memory one byte per accepted beat and assembles 32-bit words.
//   Each finished word is queued with its PC in a small prefetch FIFO. A
//   branch/jump redirect flushes the FIFO and the partial word, then restarts
//   fetch at the new, word-aligned PC.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   fetch_enable   1 = may start new words; 0 = finish current word, then stall
//   mem_req        byte read request (registered state only, never from mem_ready)
//   mem_addr       byte address = fetch_pc + byte_idx
//   mem_ready      mem_rdata valid; a beat is accepted on mem_req & mem_ready
//   mem_rdata      returned byte
//   redirect_valid restart fetch at redirect_pc (highest priority)
//   redirect_pc    new PC, low two bits ignored
//   inst_valid     FIFO head holds an instruction
//   inst_data      head instruction word (0 when empty)
//   inst_pc        head instruction PC (0 when empty)
//   inst_ready     consumer takes the head on inst_valid & inst_ready
//   fifo_count     occupied FIFO entries, 0..FIFO_DEPTH
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fetch_enable,
    output logic                          mem_req,
    output logic [31:0]                   mem_addr,
    input  logic                          mem_ready,
    input  logic [7:0]                    mem_rdata,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic                          inst_valid,
    output logic [31:0]                   inst_data,
    output logic [31:0]                   inst_pc,
    input  logic                          inst_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE    = 1;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q;
    logic [1:0]    byte_idx_q;
    logic [23:0]   word_q;      // bytes 0..2 of the word under assembly

    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    logic beat, last_beat, push, pop;

    assign mem_req   = (state_q == FETCH);
    assign mem_addr  = fetch_pc_q + {30'd0, byte_idx_q};
    assign beat      = mem_req & mem_ready;
    assign last_beat = beat && (byte_idx_q == 2'd3);

    // A redirect discards both the word completing this cycle and any pop.
    assign push = last_beat & ~redirect_valid;
    assign pop  = inst_valid & inst_ready & ~redirect_valid;

    assign inst_valid = (count_q != '0);
    assign fifo_count = count_q;
    assign inst_data  = inst_valid ? fifo_data[rd_ptr_q] : 32'd0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr_q]   : 32'd0;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d = count_q;
        if (redirect_valid)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + COUNT_ONE;
        else if (pop && !push)
            count_d = count_q - COUNT_ONE;
    end

    // A word is only started with a free slot; that slot stays reserved for
    // the in-flight word, so the push at its last beat can never overflow.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_enable && count_q < FULL_COUNT)
                    state_d = FETCH;
            end
            FETCH: begin
                if (last_beat)
                    state_d = (fetch_enable && count_d < FULL_COUNT) ? FETCH : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid)
            state_d = fetch_enable ? FETCH : IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            byte_idx_q <= 2'd0;
            word_q     <= 24'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (redirect_valid) begin
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
                byte_idx_q <= 2'd0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
            end else begin
                if (beat) begin
                    // Big-endian: byte at addr+0 lands in [31:24].
                    unique case (byte_idx_q)
                        2'd0:    word_q[23:16] <= mem_rdata;
                        2'd1:    word_q[15:8]  <= mem_rdata;
                        2'd2:    word_q[7:0]   <= mem_rdata;
                        default: ;  // last byte goes straight into the FIFO
                    endcase
                    byte_idx_q <= byte_idx_q + 2'd1;
                    if (last_beat) begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        wr_ptr_q   <= wr_ptr_q + PTR_ONE;
                    end
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; only the pointers and
    // count are, and the outputs are gated to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= {word_q, mem_rdata};
            fifo_pc[wr_ptr_q]   <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Self-checking bench for instruction_fetch_unit. The memory is a pure
//   function of the address. The expected instruction stream is a queue of
//   PCs: sequential from the last restart point (reset or redirect). Every
//   real pop must deliver the next PC of that stream along with the memory
//   word at that PC. Directed scenarios cover latency, fill/stall, ready
//   toggling, redirects and asynchronous reset. A random phase follows.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        fetch_enable;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    instruction_fetch_unit #(
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .fetch_enable   (fetch_enable),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fifo_count     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] lo;
        case (a)
            32'd0:   return 8'h02;
            32'd1:   return 8'h50;
            32'd2:   return 8'h88;
            32'd3:   return 8'h20;
            default: begin
                lo = a[7:0];
                return (lo * 8'd7) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3c;
            end
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {mem_byte(pc), mem_byte(pc + 32'd1), mem_byte(pc + 32'd2), mem_byte(pc + 32'd3)};
    endfunction

    assign mem_rdata = mem_byte(mem_addr);

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference stream: the PCs the consumer must see, in order.
    logic [31:0] exp_q[$];
    logic [31:0] model_next_pc = RST_PC;

    function automatic void model_restart(input logic [31:0] pc);
        exp_q.delete();
        model_next_pc = pc;
    endfunction

    function automatic void model_refill();
        while (exp_q.size() < DEPTH) begin
            exp_q.push_back(model_next_pc);
            model_next_pc = model_next_pc + 32'd4;
        end
    endfunction

    // Monitor: samples on the falling edge, i.e. the values the next rising
    // edge will act on.
    logic        hold_pending = 1'b0;
    logic [31:0] hold_addr    = 32'd0;

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            model_restart(RST_PC);
            hold_pending = 1'b0;
        end else begin
            check("valid_vs_count", {31'd0, inst_valid}, {31'd0, (fifo_count != 3'd0)});
            if (fifo_count > 3'(DEPTH))
                check("count_max", {29'd0, fifo_count}, DEPTH);
            if (hold_pending) begin
                check("hold_req", {31'd0, mem_req}, 32'd1);
                check("hold_addr", mem_addr, hold_addr);
            end
            hold_pending = mem_req && !mem_ready && !redirect_valid;
            hold_addr    = mem_addr;
            if (redirect_valid) begin
                model_restart({redirect_pc[31:2], 2'b00});
            end else if (inst_valid && inst_ready) begin
                model_refill();
                e = exp_q.pop_front();
                check("pop_pc", inst_pc, e);
                check("pop_data", inst_data, mem_word(e));
                pops++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [2:0] c;

        rst_n          = 1'b1;
        fetch_enable   = 1'b1;
        mem_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        inst_ready     = 1'b0;
        #2;

        // ---- 1: reset state and first-word latency ----
        rst_n = 1'b0;
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();
        check("lat_not_yet", {31'd0, inst_valid}, 32'd0);
        step();
        check("lat_valid", {31'd0, inst_valid}, 32'd1);
        check("lat_data", inst_data, 32'h0250_8820);
        check("lat_pc", inst_pc, 32'd0);

        // ---- 2: fill to depth, stall, one pop restarts fetch at 0x10 ----
        repeat (40) step();
        check("full_count", {29'd0, fifo_count}, DEPTH);
        check("full_no_req", {31'd0, mem_req}, 32'd0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        n = 0;
        while (!mem_req && n < 10) begin step(); n++; end
        check("refetch_req", {31'd0, mem_req}, 32'd1);
        check("refetch_addr", mem_addr, 32'h10);

        // ---- 3: mem_ready toggling while draining ----
        inst_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            mem_ready = (i % 2 == 0);
            step();
        end
        mem_ready = 1'b1;

        // ---- 4: redirect to 0x103 after two beats, three entries queued ----
        inst_ready = 1'b0;
        do_reset();
        n = 0;
        while (fifo_count != 3'd3 && n < 40) begin step(); n++; end
        check("redir_setup_count", {29'd0, fifo_count}, 32'd3);
        repeat (2) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        step();
        redirect_valid = 1'b0;
        check("redir_valid", {31'd0, inst_valid}, 32'd0);
        check("redir_count", {29'd0, fifo_count}, 32'd0);
        check("redir_addr", mem_addr, 32'h100);
        inst_ready = 1'b1;
        repeat (20) step();

        // ---- 5: redirect colliding with a pop and the fourth beat ----
        inst_ready = 1'b0;
        n = 0;
        while (!(fifo_count != 3'd0 && mem_req && mem_addr[1:0] == 2'd3) && n < 40) begin
            step(); n++;
        end
        check("col_setup_valid", {31'd0, inst_valid}, 32'd1);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        step();
        redirect_valid = 1'b0;
        check("col_count", {29'd0, fifo_count}, 32'd0);
        check("col_valid", {31'd0, inst_valid}, 32'd0);
        check("col_addr", mem_addr, 32'h2000);
        repeat (20) step();

        // ---- 6: asynchronous reset mid-word with two entries ----
        inst_ready = 1'b0;
        n = 0;
        while (!(fifo_count == 3'd2 && mem_req && mem_addr[1:0] == 2'd2) && n < 40) begin
            step(); n++;
        end
        check("arst_setup_count", {29'd0, fifo_count}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_req", {31'd0, mem_req}, 32'd0);
        check("arst_valid", {31'd0, inst_valid}, 32'd0);
        check("arst_count", {29'd0, fifo_count}, 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        n = 0;
        while (!mem_req && n < 10) begin step(); n++; end
        check("arst_restart_req", {31'd0, mem_req}, 32'd1);
        check("arst_restart_addr", mem_addr, RST_PC);

        // ---- 7: fetch_enable dropped mid-word still completes the word ----
        n = 0;
        while (!(mem_req && mem_addr[1:0] == 2'd1 && fifo_count <= 3'd2) && n < 40) begin
            step(); n++;
        end
        c = fifo_count;
        fetch_enable = 1'b0;
        repeat (3) step();
        check("fe0_pushed", {29'd0, fifo_count}, {29'd0, c + 3'd1});
        check("fe0_idle", {31'd0, mem_req}, 32'd0);
        repeat (5) step();
        check("fe0_stays_idle", {31'd0, mem_req}, 32'd0);
        check("fe0_count_hold", {29'd0, fifo_count}, {29'd0, c + 3'd1});
        fetch_enable = 1'b1;

        // ---- random phase ----
        for (int i = 0; i < 3000; i++) begin
            mem_ready      = ($urandom % 4) != 0;
            inst_ready     = ($urandom % 3) != 0;
            fetch_enable   = ($urandom % 8) != 0;
            redirect_valid = ($urandom % 48) == 0;
            redirect_pc    = $urandom;
            step();
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        repeat (10) step();
        check("enough_pops", {31'd0, (pops > 200)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
